// File: rtl/gcn_pkg.sv
// Shared constants and types for the GameCube controller response receiver.
// Timing constants are in 32 MHz clock cycles (31.25 ns each).
package gcn_pkg;

  localparam int GCN_NBITS      = 64;    // response bits per frame
  localparam int GCN_BIT_THRESH = 64;    // 2us: shorter low is a 1, this or longer is a 0
  localparam int GCN_LOW_MAX    = 160;   // 5us: low pulse longer than this is a fault
  localparam int GCN_HIGH_MAX   = 256;   // 8us: high gap longer than this aborts the frame
  localparam int GCN_START_MAX  = 6400;  // 200us: wait for the controller to start replying

  localparam logic [1:0] ERR_NOSTART = 2'd0;
  localparam logic [1:0] ERR_LOWLONG = 2'd1;
  localparam logic [1:0] ERR_HIGHTO  = 2'd2;
  localparam logic [1:0] ERR_STOP    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_LOW,
    S_HIGH,
    S_STOP,
    S_DONE,
    S_ERR
  } rx_state_t;

endpackage

// File: rtl/gcn_rx_sync.sv
// Input conditioning for the controller data pin: 2-flop synchroniser,
// optional 3-sample majority filter (GCN_RX_GLITCH_FILTER_EN), and
// single-cycle fall/rise pulses on the conditioned level.
// The line idles high, so every stage resets to 1 to avoid a false edge.
module gcn_rx_sync (
  input  logic clk32MHz,
  input  logic rst_n,
  input  logic pin_in,
  output logic fall,
  output logic rise
);

  logic meta;
  logic synced;
  logic lvl;
  logic prev_lvl;

  // two-flop synchroniser for the asynchronous open-drain pin
  always_ff @(posedge clk32MHz or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b1;
      synced <= 1'b1;
    end else begin
      meta   <= pin_in;
      synced <= meta;
    end
  end

`ifdef GCN_RX_GLITCH_FILTER_EN
  logic hist1;
  logic hist2;

  // keep the two previous synced samples so one-cycle spikes are outvoted
  always_ff @(posedge clk32MHz or negedge rst_n) begin
    if (!rst_n) begin
      hist1 <= 1'b1;
      hist2 <= 1'b1;
    end else begin
      hist1 <= synced;
      hist2 <= hist1;
    end
  end

  assign lvl = (synced & hist1) | (synced & hist2) | (hist1 & hist2);
`else
  assign lvl = synced;
`endif

  // remember the previous conditioned level for edge detection
  always_ff @(posedge clk32MHz or negedge rst_n) begin
    if (!rst_n) begin
      prev_lvl <= 1'b1;
    end else begin
      prev_lvl <= lvl;
    end
  end

  assign fall = prev_lvl & ~lvl;
  assign rise = ~prev_lvl & lvl;

endmodule

// File: rtl/gcn_rx.sv
// GameCube controller response receiver. After arm, measures the low time of
// each bit on the data pin (short low = 1, long low = 0), collects NBITS bits
// MSB first, checks the short stop bit and presents the word with a valid pulse.
// Faults end the frame with an err pulse and an err_code that is held.
// Optional macro GCN_RX_GLITCH_FILTER_EN adds a majority filter on the pin.
module gcn_rx
  import gcn_pkg::*;
#(
  parameter int NBITS      = GCN_NBITS,
  parameter int BIT_THRESH = GCN_BIT_THRESH,
  parameter int LOW_MAX    = GCN_LOW_MAX,
  parameter int HIGH_MAX   = GCN_HIGH_MAX,
  parameter int START_MAX  = GCN_START_MAX
) (
  input  logic             clk32MHz,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             pin_in,
  output logic [NBITS-1:0] rx_data,
  output logic             valid,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             busy
);

  localparam int CW = $clog2(START_MAX + 1);
  localparam int BW = $clog2(NBITS + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] THRESH_C  = CW'(BIT_THRESH);
  localparam logic [CW-1:0] LOWMAX_C  = CW'(LOW_MAX);
  localparam logic [CW-1:0] HIGHMAX_C = CW'(HIGH_MAX);
  localparam logic [CW-1:0] START_C   = CW'(START_MAX);
  localparam logic [BW-1:0] NBITS_C   = BW'(NBITS);

  rx_state_t        state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bitcnt;
  logic [NBITS-1:0] shreg;
  logic             fall;
  logic             rise;

  gcn_rx_sync u_sync (
    .clk32MHz (clk32MHz),
    .rst_n    (rst_n),
    .pin_in   (pin_in),
    .fall     (fall),
    .rise     (rise)
  );

  // Receive FSM. On an edge the counter restarts at 1 because the edge cycle
  // is already the first cycle of the new level, so cnt equals the pulse width
  // in cycles when the closing edge arrives. Every timeout leaves the state
  // as soon as cnt reaches its limit, so cnt never counts past the limit.
  // DONE and ERR are the single cycle in which valid/err are high.
  always_ff @(posedge clk32MHz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arm) begin
            state <= S_WAIT_START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        S_WAIT_START: begin
          if (fall) begin
            state  <= S_LOW;
            cnt    <= CNT_ONE;
            bitcnt <= '0;
          end else if (cnt >= START_C) begin
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= ERR_NOSTART;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_LOW: begin
          if (rise) begin
            shreg  <= {shreg[NBITS-2:0], (cnt < THRESH_C)};
            bitcnt <= bitcnt + 1'b1;
            cnt    <= CNT_ONE;
            state  <= S_HIGH;
          end else if (cnt >= LOWMAX_C) begin
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= ERR_LOWLONG;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (fall) begin
            cnt   <= CNT_ONE;
            state <= (bitcnt == NBITS_C) ? S_STOP : S_LOW;
          end else if (cnt >= HIGHMAX_C) begin
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= ERR_HIGHTO;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (rise) begin
            if (cnt < THRESH_C) begin
              state   <= S_DONE;
              rx_data <= shreg;
              valid   <= 1'b1;
            end else begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_STOP;
            end
          end else if (cnt >= LOWMAX_C) begin
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= ERR_STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_DONE, S_ERR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcn_rx.sv
// Self-checking bench for gcn_rx: table of whole frames plus hand-written
// fault sequences; expected results go through a scoreboard queue that is
// popped whenever the receiver pulses valid or err.
`timescale 1ns/1ps
module tb_gcn_rx;
  import gcn_pkg::*;

  logic        clk32MHz = 1'b0;
  logic        rst_n    = 1'b0;
  logic        arm      = 1'b0;
  logic        pin_in   = 1'b1;
  logic [63:0] rx_data;
  logic        valid;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

`ifdef GCN_RX_GLITCH_FILTER_EN
  localparam int VLAT = 4;
`else
  localparam int VLAT = 3;
`endif

  gcn_rx dut (
    .clk32MHz (clk32MHz),
    .rst_n    (rst_n),
    .arm      (arm),
    .pin_in   (pin_in),
    .rx_data  (rx_data),
    .valid    (valid),
    .err      (err),
    .err_code (err_code),
    .busy     (busy)
  );

  always #16 clk32MHz = ~clk32MHz;

  typedef struct {
    bit          isErr;
    logic [63:0] data;
    logic [1:0]  code;
    bit          chkLat;
  } exp_t;

  typedef struct {
    logic [63:0] data;
    int          stopLow;
    bit          isErr;
    logic [1:0]  code;
  } vec_t;

  exp_t        sbq[$];
  exp_t        popped;
  vec_t        vecs[3];
  int          total       = 0;
  int          bad         = 0;
  int          cycle       = 0;
  int          riseCycle   = 0;
  int          pulseCycle  = -1;
  int          lastErrCycle = 0;
  int          armCycle    = 0;
  logic [63:0] lastGood    = 64'h0;

  // free-running cycle count used for latency and timeout measurements
  always @(posedge clk32MHz) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic pushExp(input bit isErr, input logic [63:0] data, input logic [1:0] code, input bit chkLat);
    exp_t e;
    e.isErr  = isErr;
    e.data   = data;
    e.code   = code;
    e.chkLat = chkLat;
    sbq.push_back(e);
  endtask

  // scoreboard monitor: sample outputs on the falling edge
  always @(negedge clk32MHz) begin
    if (pulseCycle >= 0 && cycle == pulseCycle + 1) begin
      checkOutput("busy_drop", 64'(busy), 64'h0);
      pulseCycle = -1;
    end
    if (valid || err) begin
      checkOutput("valid_err_excl", 64'(valid & err), 64'h0);
      checkOutput("busy_in_pulse", 64'(busy), 64'h1);
      pulseCycle = cycle;
      if (err) lastErrCycle = cycle;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_pulse: got valid=%b err=%b want none", valid, err);
      end else begin
        popped = sbq.pop_front();
        checkOutput("pulse_kind", 64'(err), 64'(popped.isErr));
        if (popped.isErr) begin
          checkOutput("err_code", 64'(err_code), 64'(popped.code));
        end else begin
          checkOutput("rx_data", rx_data, popped.data);
          if (popped.chkLat) checkOutput("valid_latency", 64'(cycle - riseCycle), 64'(VLAT));
        end
      end
    end
  end

  task automatic sendBit(input int lowCyc, input int highCyc, input bit spike);
    pin_in = 1'b0;
    repeat (lowCyc) @(negedge clk32MHz);
    pin_in = 1'b1;
    riseCycle = cycle;
    if (spike) begin
      repeat (highCyc / 2) @(negedge clk32MHz);
      pin_in = 1'b0;
      @(negedge clk32MHz);
      pin_in = 1'b1;
      repeat (highCyc - highCyc / 2 - 1) @(negedge clk32MHz);
    end else begin
      repeat (highCyc) @(negedge clk32MHz);
    end
  endtask

  // send nbits wire bits of d (MSB first); bit idx uses custom timing;
  // the stop bit is only sent for a complete frame
  task automatic applyStimulus(input logic [63:0] d, input int nbits, input int idx,
                               input int lowLen, input int highLen, input int stopLow,
                               input int spikeIdx);
    for (int i = 0; i < nbits; i++) begin
      int lo;
      int hi;
      lo = d[63-i] ? 32 : 96;
      hi = d[63-i] ? 96 : 32;
      if (i == idx) begin
        lo = lowLen;
        hi = highLen;
      end
      sendBit(lo, hi, (i == spikeIdx));
    end
    if (nbits == 64) sendBit(stopLow, 20, 1'b0);
  endtask

  task automatic armPulse();
    @(negedge clk32MHz);
    arm = 1'b1;
    armCycle = cycle;
    @(negedge clk32MHz);
    arm = 1'b0;
    repeat (4) @(negedge clk32MHz);
  endtask

  task automatic waitDrain(input int bound);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < bound) begin
      @(negedge clk32MHz);
      n++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending want 0", sbq.size());
      sbq.delete();
    end
    repeat (4) @(negedge clk32MHz);
  endtask

  initial begin
    vecs[0] = '{data: 64'h0080_8080_8080_0000, stopLow: 32,  isErr: 1'b0, code: 2'd0};
    vecs[1] = '{data: 64'h0,                   stopLow: 32,  isErr: 1'b0, code: 2'd0};
    vecs[2] = '{data: 64'h1234_5678_9ABC_DEF0, stopLow: 100, isErr: 1'b1, code: ERR_STOP};
    vecs[1].data = {$urandom, $urandom};

    // reset state
    #40;
    checkOutput("reset_rx_data", rx_data, 64'h0);
    checkOutput("reset_flags", {60'h0, valid, err, busy, 1'b0}, 64'h0);
    checkOutput("reset_err_code", 64'(err_code), 64'h0);
    @(negedge clk32MHz);
    rst_n = 1'b1;
    repeat (4) @(negedge clk32MHz);

    // table-driven frames
    for (int v = 0; v < 3; v++) begin
      pushExp(vecs[v].isErr, vecs[v].data, vecs[v].code, !vecs[v].isErr);
      armPulse();
      applyStimulus(vecs[v].data, 64, -1, 0, 0, vecs[v].stopLow, -1);
      waitDrain(500);
      if (vecs[v].isErr) checkOutput("rx_hold_stop", rx_data, lastGood);
      else lastGood = vecs[v].data;
    end

    // no start bit
    pushExp(1'b1, 64'h0, ERR_NOSTART, 1'b0);
    armPulse();
    waitDrain(7000);
    checkOutput("nostart_window",
                64'(((lastErrCycle - armCycle) >= 6400) && ((lastErrCycle - armCycle) <= 6410)), 64'h1);

    // bit 10 low too long
    pushExp(1'b1, 64'h0, ERR_LOWLONG, 1'b0);
    armPulse();
    applyStimulus(64'hFFFF_0000_FFFF_0000, 11, 10, 200, 40, 0, -1);
    waitDrain(500);
    checkOutput("rx_hold_lowlong", rx_data, lastGood);

    // high timeout after bit 20, then recovery with threshold frame (64 low -> 0)
    pushExp(1'b1, 64'h0, ERR_HIGHTO, 1'b0);
    armPulse();
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 21, 20, 32, 300, 0, -1);
    waitDrain(500);
    pushExp(1'b0, 64'hFBFF_FFFF_FFFF_FFFF, 2'd0, 1'b1);
    armPulse();
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64, 5, 64, 64, 32, -1);
    waitDrain(500);
    checkOutput("err_code_held", 64'(err_code), 64'(ERR_HIGHTO));

    // 63 cycles low -> 1
    pushExp(1'b0, 64'h0100_0000_0000_0000, 2'd0, 1'b1);
    armPulse();
    applyStimulus(64'h0, 64, 7, 63, 64, 32, -1);
    waitDrain(500);

    // reset during bit 30 discards the frame silently
    armPulse();
    applyStimulus(64'hA5A5_A5A5_A5A5_A5A5, 30, -1, 0, 0, 0, -1);
    pin_in = 1'b0;
    repeat (10) @(negedge clk32MHz);
    rst_n = 1'b0;
    repeat (3) @(negedge clk32MHz);
    checkOutput("midreset_rx_data", rx_data, 64'h0);
    checkOutput("midreset_busy", 64'(busy), 64'h0);
    pin_in = 1'b1;
    @(negedge clk32MHz);
    rst_n = 1'b1;
    repeat (300) @(negedge clk32MHz);
    checkOutput("midreset_no_pulse", 64'(sbq.size()), 64'h0);

`ifdef GCN_RX_GLITCH_FILTER_EN
    // good frame with a one-cycle spike in the high part of bit 3
    pushExp(1'b0, 64'hC3C3_5A5A_0F0F_F00F, 2'd0, 1'b1);
    armPulse();
    applyStimulus(64'hC3C3_5A5A_0F0F_F00F, 64, -1, 0, 0, 32, 3);
    waitDrain(500);
`else
    pushExp(1'b0, 64'hC3C3_5A5A_0F0F_F00F, 2'd0, 1'b1);
    armPulse();
    applyStimulus(64'hC3C3_5A5A_0F0F_F00F, 64, -1, 0, 0, 32, -1);
    waitDrain(500);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
